// File: rtl/simple_proc_pkg.sv
// Shared encodings for the multi-cycle processor control path.
package simple_proc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_FAULT    = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // States that wait on the memory ready handshake.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the
// cycle in which the wait limit is reached. MEM_TIMEOUT = 0 disables it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  input  logic ready,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Wait counter: restarts on every state change, advances while stalled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_en && !ready) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign timeout = 1'b0;
    end else begin : g_on
      assign timeout = count_en && !ready && (count == CW'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath selects and strobes, detects faults, counts retirements.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  FETCH    | read instruction, PC+4; waits on memory ready
//  DECODE   | read registers, branch target; dispatch opcode
//  EXEC_R   | R-type ALU operation
//  R_WB     | R-type result to rd
//  MEM_ADDR | effective address for LW/SW
//  MEM_RD   | data read; waits on memory ready
//  MEM_WB   | load data to rt
//  MEM_WR   | data write; waits on memory ready
//  BRANCH   | compare and conditional PC update
//  JUMP     | PC <= jump target
//  FAULT    | illegal opcode or memory timeout; held until reset
module multicycle_control
  import simple_proc_pkg::*;
#(
  parameter int                  OPCODE_W    = 6,
  parameter logic [OPCODE_W-1:0] OP_ADD      = 6'b000001,
  parameter logic [OPCODE_W-1:0] OP_SW       = 6'b000010,
  parameter logic [OPCODE_W-1:0] OP_LW       = 6'b000100,
  parameter logic [OPCODE_W-1:0] OP_BEQ      = 6'b001000,
  parameter logic [OPCODE_W-1:0] OP_J        = 6'b010000,
  parameter int                  MEM_TIMEOUT = 15,
  parameter int                  CNT_W       = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_memReady,
  output logic                o_PCWrite,
  output logic                o_PCWriteCond,
  output logic                o_IRWrite,
  output logic                o_regWrite,
  output logic                o_memRead,
  output logic                o_memWrite,
  output logic                o_IorD,
  output logic                o_regDst,
  output logic                o_memToReg,
  output logic                o_ALUSrcA,
  output logic [1:0]          o_ALUSrcB,
  output logic [1:0]          o_ALUop,
  output logic [1:0]          o_PCSource,
  output logic                o_fault,
  output logic [1:0]          o_faultCode,
  output logic [CNT_W-1:0]    o_retired,
  output logic [3:0]          o_state
);

  state_t     state, state_next;
  logic       is_lw;
  logic       timeout;
  logic       retire;
  logic [1:0] fault_code_next;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (state_next != state),
    .count_en (is_mem_state(state)),
    .ready    (i_memReady),
    .timeout  (timeout)
  );

  // Leaving any terminal instruction state back to FETCH retires it.
  assign retire = (state_next == S_FETCH) &&
                  ((state == S_R_WB) || (state == S_MEM_WB) || (state == S_MEM_WR) ||
                   (state == S_BRANCH) || (state == S_JUMP));

  // State, latched load/store choice, fault code and retire counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_FETCH;
      is_lw       <= 1'b0;
      o_faultCode <= FAULT_NONE;
      o_retired   <= '0;
    end else begin
      state       <= state_next;
      o_faultCode <= fault_code_next;
      if (state == S_DECODE) begin
        is_lw <= (i_opcode == OP_LW);
      end
      if (retire) begin
        o_retired <= o_retired + 1'b1;
      end
    end
  end

  // Next-state and per-state output decode; write strobes masked in reset.
  always_comb begin
    state_next      = state;
    fault_code_next = o_faultCode;
    o_PCWrite       = 1'b0;
    o_PCWriteCond   = 1'b0;
    o_IRWrite       = 1'b0;
    o_regWrite      = 1'b0;
    o_memRead       = 1'b0;
    o_memWrite      = 1'b0;
    o_IorD          = 1'b0;
    o_regDst        = 1'b0;
    o_memToReg      = 1'b0;
    o_ALUSrcA       = 1'b0;
    o_ALUSrcB       = SRCB_REG;
    o_ALUop         = ALUOP_ADD;
    o_PCSource      = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        o_memRead  = 1'b1;
        o_ALUSrcB  = SRCB_FOUR;
        o_IRWrite  = i_memReady;
        o_PCWrite  = i_memReady;
        if (i_memReady) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        o_ALUSrcB = SRCB_SHIFT;
        if (i_opcode == OP_ADD) begin
          state_next = S_EXEC_R;
        end else if ((i_opcode == OP_LW) || (i_opcode == OP_SW)) begin
          state_next = S_MEM_ADDR;
        end else if (i_opcode == OP_BEQ) begin
          state_next = S_BRANCH;
        end else if (i_opcode == OP_J) begin
          state_next = S_JUMP;
        end else begin
          state_next      = S_FAULT;
          fault_code_next = FAULT_ILLEGAL;
        end
      end
      S_EXEC_R: begin
        o_ALUSrcA  = 1'b1;
        o_ALUop    = ALUOP_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        o_regDst   = 1'b1;
        o_regWrite = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        o_ALUSrcA  = 1'b1;
        o_ALUSrcB  = SRCB_IMM;
        state_next = is_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        o_memRead = 1'b1;
        o_IorD    = 1'b1;
        if (i_memReady) begin
          state_next = S_MEM_WB;
        end else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = FAULT_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        o_memToReg = 1'b1;
        o_regWrite = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        o_memWrite = 1'b1;
        o_IorD     = 1'b1;
        if (i_memReady) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = FAULT_TIMEOUT;
        end
      end
      S_BRANCH: begin
        o_ALUSrcA     = 1'b1;
        o_ALUop       = ALUOP_SUB;
        o_PCWriteCond = 1'b1;
        o_PCSource    = PCSRC_ALUOUT;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        o_PCWrite  = 1'b1;
        o_PCSource = PCSRC_JUMP;
        state_next = S_FETCH;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
    if (i_rst) begin
      o_PCWrite     = 1'b0;
      o_PCWriteCond = 1'b0;
      o_IRWrite     = 1'b0;
      o_regWrite    = 1'b0;
      o_memWrite    = 1'b0;
    end
  end

  assign o_fault = (state == S_FAULT);
  assign o_state = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-path model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_multicycle_control;
  import simple_proc_pkg::*;

  localparam int         TMO    = 15;
  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SW  = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b000100;
  localparam logic [5:0] OP_BEQ = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b010000;
  localparam logic [5:0] JUNK   = 6'b111111;

  typedef struct packed {
    logic pcw, pcwc, irw, rw, mr, mw, iord, rdst, mtr, srca;
    logic [1:0] srcb, aluop, pcsrc;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rdy;
  logic [5:0] op;

  logic pcw, pcwc, irw, rw, mr, mw, iord, rdst, mtr, srca, fault;
  logic [1:0] srcb, aluop, pcsrc, fcode;
  logic [15:0] ret;
  logic [3:0]  st;

  logic b_pcw, b_pcwc, b_irw, b_rw, b_mr, b_mw, b_iord, b_rdst, b_mtr, b_srca, b_fault;
  logic [1:0] b_srcb, b_aluop, b_pcsrc, b_fcode;
  logic [1:0] b_ret;
  logic [3:0] b_st;

  multicycle_control dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_memReady(rdy),
    .o_PCWrite(pcw), .o_PCWriteCond(pcwc), .o_IRWrite(irw), .o_regWrite(rw),
    .o_memRead(mr), .o_memWrite(mw), .o_IorD(iord), .o_regDst(rdst),
    .o_memToReg(mtr), .o_ALUSrcA(srca), .o_ALUSrcB(srcb), .o_ALUop(aluop),
    .o_PCSource(pcsrc), .o_fault(fault), .o_faultCode(fcode),
    .o_retired(ret), .o_state(st)
  );

  multicycle_control #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_memReady(rdy),
    .o_PCWrite(b_pcw), .o_PCWriteCond(b_pcwc), .o_IRWrite(b_irw), .o_regWrite(b_rw),
    .o_memRead(b_mr), .o_memWrite(b_mw), .o_IorD(b_iord), .o_regDst(b_rdst),
    .o_memToReg(b_mtr), .o_ALUSrcA(b_srca), .o_ALUSrcB(b_srcb), .o_ALUop(b_aluop),
    .o_PCSource(b_pcsrc), .o_fault(b_fault), .o_faultCode(b_fcode),
    .o_retired(b_ret), .o_state(b_st)
  );

  ctl_t act1, act2;
  assign act1 = {pcw, pcwc, irw, rw, mr, mw, iord, rdst, mtr, srca, srcb, aluop, pcsrc};
  assign act2 = {b_pcw, b_pcwc, b_irw, b_rw, b_mr, b_mw, b_iord, b_rdst, b_mtr, b_srca,
                 b_srcb, b_aluop, b_pcsrc};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Control word each phase must present, straight from the phase descriptions.
  function automatic ctl_t exp_ctl(state_t p, logic y, logic r);
    ctl_t c;
    c = '0;
    case (p)
      S_FETCH:    begin c.mr = 1; c.srcb = 2'b01; c.irw = y; c.pcw = y; end
      S_DECODE:   begin c.srcb = 2'b11; end
      S_EXEC_R:   begin c.srca = 1; c.aluop = 2'b10; end
      S_R_WB:     begin c.rdst = 1; c.rw = 1; end
      S_MEM_ADDR: begin c.srca = 1; c.srcb = 2'b10; end
      S_MEM_RD:   begin c.mr = 1; c.iord = 1; end
      S_MEM_WB:   begin c.mtr = 1; c.rw = 1; end
      S_MEM_WR:   begin c.mw = 1; c.iord = 1; end
      S_BRANCH:   begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      S_JUMP:     begin c.pcw = 1; c.pcsrc = 2'b10; end
      default:    c = '0;
    endcase
    if (r) begin
      c.pcw = 0; c.pcwc = 0; c.irw = 0; c.rw = 0; c.mw = 0;
    end
    return c;
  endfunction

  // Model: current phase plus the queue of phases left in this instruction.
  state_t     m_cur;
  state_t     m_path[$];
  int         m_wait;
  int         m_ret;
  logic [1:0] m_code;
  bit         chk_en = 0;

  // Model update at each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    bit adv;
    if (rst) begin
      m_cur = S_FETCH;
      m_path.delete();
      m_path.push_back(S_DECODE);
      m_wait = 0;
      m_ret  = 0;
      m_code = 2'b00;
      chk_en = 1;
    end else if (chk_en) begin
      adv = 0;
      if (m_cur == S_FAULT) begin
        adv = 0;
      end else if (m_cur == S_DECODE) begin
        m_path.delete();
        adv = 1;
        if (op == OP_ADD) begin
          m_path.push_back(S_EXEC_R); m_path.push_back(S_R_WB);
        end else if (op == OP_LW) begin
          m_path.push_back(S_MEM_ADDR); m_path.push_back(S_MEM_RD); m_path.push_back(S_MEM_WB);
        end else if (op == OP_SW) begin
          m_path.push_back(S_MEM_ADDR); m_path.push_back(S_MEM_WR);
        end else if (op == OP_BEQ) begin
          m_path.push_back(S_BRANCH);
        end else if (op == OP_J) begin
          m_path.push_back(S_JUMP);
        end else begin
          adv = 0; m_cur = S_FAULT; m_code = 2'b01;
        end
      end else if (m_cur == S_FETCH || m_cur == S_MEM_RD || m_cur == S_MEM_WR) begin
        if (rdy) adv = 1;
        else if (m_wait == TMO - 1) begin m_cur = S_FAULT; m_code = 2'b10; end
        else m_wait++;
      end else begin
        adv = 1;
      end
      if (adv) begin
        m_wait = 0;
        if (m_path.size() == 0) begin
          m_ret++;
          m_cur = S_FETCH;
          m_path.push_back(S_DECODE);
        end else begin
          m_cur = m_path.pop_front();
        end
      end
    end
  end

  // Every-cycle comparison of both DUT instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl", 32'(act1), 32'(exp_ctl(m_cur, rdy, rst)));
      chk("state", 32'(st), 32'(m_cur));
      chk("fault", 32'(fault), 32'(m_cur == S_FAULT));
      chk("fault_code", 32'(fcode), 32'(m_code));
      chk("retired", 32'(ret), 32'(m_ret % 65536));
      chk("ctl_w2", 32'(act2), 32'(exp_ctl(m_cur, rdy, rst)));
      chk("state_w2", 32'(b_st), 32'(m_cur));
      chk("fault_w2", 32'(b_fault), 32'(m_cur == S_FAULT));
      chk("fault_code_w2", 32'(b_fcode), 32'(m_code));
      chk("retired_w2", 32'(b_ret), 32'(m_ret % 4));
    end
  end

  task automatic cyc(input logic r, input logic [5:0] o, input logic y);
    rst = r; op = o; rdy = y;
    @(posedge clk); #1;
  endtask

  ctl_t       last_ctl;
  logic [3:0] last_st;
  int         mw_cnt;

  // One instruction; w not-ready cycles in its data-memory phase.
  task automatic instr(input logic [5:0] o, input int w);
    int len, memi;
    len  = (o == OP_LW) ? 5 : ((o == OP_BEQ || o == OP_J) ? 3 : 4);
    memi = (o == OP_LW || o == OP_SW) ? 3 : -1;
    if (memi < 0) w = 0;
    mw_cnt = 0;
    for (int c = 0; c < len + w; c++) begin
      rst = 0;
      op  = (c == 1) ? o : JUNK;
      rdy = (c == 0) || (memi >= 0 && c == memi + w);
      #1;
      last_ctl = act1;
      last_st  = st;
      if (mw) mw_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1; rdy = 0; op = JUNK;
    cyc(1, JUNK, 0);
    cyc(1, JUNK, 0);
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_retired", 32'(ret), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_code", 32'(fcode), 32'd0);

    instr(OP_ADD, 0);
    chk("add_last_state", 32'(last_st), 32'(S_R_WB));
    chk("add_regwrite", 32'(last_ctl.rw), 32'd1);
    chk("add_regdst", 32'(last_ctl.rdst), 32'd1);
    chk("add_back_fetch", 32'(st), 32'd0);
    chk("add_retired", 32'(ret), 32'd1);

    instr(OP_LW, 3);
    chk("lw_last_state", 32'(last_st), 32'(S_MEM_WB));
    chk("lw_memtoreg", 32'(last_ctl.mtr), 32'd1);
    chk("lw_regwrite", 32'(last_ctl.rw), 32'd1);
    chk("lw_retired", 32'(ret), 32'd2);

    cyc(1, JUNK, 0);
    instr(OP_SW, 0);
    chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd1);
    instr(OP_BEQ, 0);
    chk("beq_pcwritecond", 32'(last_ctl.pcwc), 32'd1);
    chk("beq_aluop", 32'(last_ctl.aluop), 32'd1);
    chk("sw_beq_retired", 32'(ret), 32'd2);
    instr(OP_J, 0);
    instr(OP_ADD, 0);
    chk("four_retired", 32'(ret), 32'd4);
    chk("wrap_retired_w2", 32'(b_ret), 32'd0);

    cyc(0, JUNK, 1);
    cyc(0, JUNK, 0);
    chk("illegal_state", 32'(st), 32'(S_FAULT));
    chk("illegal_code", 32'(fcode), 32'd1);
    for (int i = 0; i < 20; i++) cyc(0, 6'($urandom), 1'($urandom));
    chk("fault_held", 32'(st), 32'(S_FAULT));
    chk("fault_flag_held", 32'(fault), 32'd1);
    cyc(1, JUNK, 0);
    chk("fault_cleared", 32'(fault), 32'd0);
    chk("fault_code_cleared", 32'(fcode), 32'd0);

    for (int i = 0; i < 14; i++) cyc(0, JUNK, 0);
    chk("tmo_not_yet", 32'(st), 32'(S_FETCH));
    cyc(0, JUNK, 0);
    chk("tmo_state", 32'(st), 32'(S_FAULT));
    chk("tmo_code", 32'(fcode), 32'd2);
    cyc(1, JUNK, 0);
    for (int i = 0; i < 14; i++) cyc(0, JUNK, 0);
    cyc(0, JUNK, 1);
    chk("late_ready_decode", 32'(st), 32'(S_DECODE));
    chk("late_ready_nofault", 32'(fault), 32'd0);
    cyc(0, OP_J, 0);
    cyc(0, JUNK, 0);
    chk("late_ready_retired", 32'(ret), 32'd1);

    cyc(1, JUNK, 0);
    instr(OP_ADD, 0);
    cyc(0, JUNK, 1);
    cyc(0, OP_LW, 0);
    cyc(0, JUNK, 0);
    cyc(0, JUNK, 1);
    chk("wb_state", 32'(st), 32'(S_MEM_WB));
    rst = 1; op = JUNK; rdy = 0;
    #1;
    chk("rst_wb_regwrite", 32'(rw), 32'd0);
    @(posedge clk); #1;
    chk("rst_wb_fetch", 32'(st), 32'd0);
    chk("rst_wb_retired", 32'(ret), 32'd0);
    cyc(0, JUNK, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the simple processor. A registered state machine sequences each instruction through fetch, decode, execute, memory and write-back states, replacing the single-cycle opcode decoder. It drives the datapath mux selects and write strobes, and waits on a memory ready handshake. It also detects illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register opcode field and the shared-memory datapath; the ALU control decoder still consumes `o_ALUop`.

## Interface
Parameters:
- `OPCODE_W`, 6: opcode field width.
- `OP_ADD`, 6'b000001: R-type add.
- `OP_SW`, 6'b000010: store word.
- `OP_LW`, 6'b000100: load word.
- `OP_BEQ`, 6'b001000: branch if equal.
- `OP_J`, 6'b010000: jump.
- `MEM_TIMEOUT`, 15: consecutive not-ready cycles that cause a fault. 0 disables the timeout.
- `CNT_W`, 16: retired-instruction counter width.

Ports:
- `i_clk`, in, 1: the single clock; all state changes on its rising edge.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_opcode`, in, OPCODE_W: opcode from the instruction register; sampled in DECODE.
- `i_memReady`, in, 1: memory has completed the current access.
- `o_PCWrite`, `o_PCWriteCond`, `o_IRWrite`, `o_regWrite`, `o_memRead`, `o_memWrite`, out, 1 each: strobes.
- `o_IorD`, `o_regDst`, `o_memToReg`, `o_ALUSrcA`, out, 1 each: mux selects.
- `o_ALUSrcB`, out, 2: 00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `o_ALUop`, out, 2: 00 = add, 01 = sub, 10 = funct.
- `o_PCSource`, out, 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `o_fault`, out, 1: sticky fault flag.
- `o_faultCode`, out, 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.
- `o_retired`, out, CNT_W: retired-instruction count.
- `o_state`, out, 4: current state encoding, for debug.

## Operation
- Outputs default to 0; each state asserts only the fields listed for it.
- FETCH: memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00.
  - IRWrite and PCWrite both equal `i_memReady`, with PCSource=00.
  - Advances to DECODE on ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by opcode:
  - ADD goes to EXEC_R.
  - LW and SW go to MEM_ADDR.
  - BEQ goes to BRANCH.
  - J goes to JUMP.
  - Any other opcode goes to FAULT with code 01.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next: R_WB.
- R_WB: regDst=1, memToReg=0, regWrite=1. Next: FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next: MEM_RD for LW, MEM_WR for SW. The opcode decision is latched in DECODE.
- MEM_RD: memRead=1, IorD=1. Advances to MEM_WB on ready.
- MEM_WB: regDst=0, memToReg=1, regWrite=1. Next: FETCH.
- MEM_WR: memWrite=1, IorD=1. Advances to FETCH on ready.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Next: FETCH. The zero flag is ANDed externally.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- FAULT: all strobes 0, `o_fault`=1. The state holds until `i_rst`.
- Memory wait timer (FETCH, MEM_RD, MEM_WR):
  - Clears on entry to a memory state.
  - Increments on each cycle with ready low.
  - If ready is still low when the count equals MEM_TIMEOUT-1, next state is FAULT with code 10.
  - Ready in that same cycle takes priority over the timeout.
- Retire counter increments by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from R_WB, MEM_WB, MEM_WR, BRANCH or JUMP. Transitions into FETCH from reset do not count.

## Timing
- Reset values:
  - state = FETCH (4'd0).
  - `o_retired` = 0, `o_fault` = 0, `o_faultCode` = 00, wait timer = 0.
  - While `i_rst` is high, PCWrite, PCWriteCond, IRWrite, regWrite and memWrite are forced to 0 regardless of state.
- Reset mid-instruction: the state is FETCH on the next edge. No partial write-back occurs.
- Cycles per instruction with zero memory wait: ADD 4, LW 5, SW 4, BEQ 3, J 3. Each cycle of ready low in a memory state adds one cycle.
- All outputs are decoded from the registered state and are stable for the whole cycle. The exception is the FETCH IRWrite/PCWrite gating, which is combinational on `i_memReady`.
- `i_opcode` is sampled only in DECODE. Changes to it in other states have no effect.
- `o_retired` updates on the same edge that enters FETCH.

## Structure
- Shared package `simple_proc_pkg` holds:
  - state encodings (4-bit localparams),
  - ALUop codes,
  - ALUSrcB and PCSource codes,
  - fault codes.
- Opcode values stay as module parameters.
- One sub-module: `mem_wait_timer`. Inputs: clear, count-enable, ready. Output: timeout pulse. Parameter: MEM_TIMEOUT.
- The FSM and output decode live in `multicycle_control`.

## Test plan
- Reset, then ADD opcode with ready always high:
  - Visits FETCH, DECODE, EXEC_R, R_WB.
  - regWrite=1 with regDst=1 in cycle 4.
  - `o_retired`=1 after return to FETCH.
- LW with ready held low for 3 cycles in MEM_RD: 8 cycles total, memToReg=1 and regWrite=1 in the final cycle.
- SW then BEQ back to back, zero wait:
  - memWrite=1 for exactly 1 cycle.
  - PCWriteCond=1 with ALUop=01 in BRANCH.
  - `o_retired`=2.
- Opcode 6'b111111:
  - FAULT after DECODE, `o_faultCode`=01.
  - All strobes 0 for 20 further cycles.
  - Reset clears the fault.
- Ready low for 15 cycles in FETCH: FAULT with code 10. Repeat with ready rising on cycle 15: normal DECODE, no fault.
- Assert `i_rst` in MEM_WB:
  - regWrite=0 in that cycle.
  - State is FETCH next.
  - `o_retired`=0.
  - Also cover counter wrap with CNT_W=2: 4 retirements give 0.
